mem_bank_write_arbiter: RTL and testbench

- Owns the single write port (wea/addra/dia) of one memory bank and shares it between two requesters: the operator-pipeline writeback and the host register-write path.
- Also runs a clear sweep that writes CLEAR_VALUE to every address, after reset and on request.
- Sits between the register/pipeline logic and the bank. Read-side signals (reb/addrb/dob) bypass this block.

---
 rtl/mem_bank_write_arbiter_if.sv | 46 ++++
 rtl/mem_bank_write_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_bank_write_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_write_arbiter_if.sv
// rtl/mem_bank_write_arbiter_if.sv - bundle of requester, control and bank write-port signals
//
// Purpose: groups everything that crosses between the write arbiter and its
// neighbours. The neighbours are the pipeline writeback, the host register
// writes, the clear control and the bank write port.
//   master : requester/bank side (drives pipe_*, host_valid/addr/data, clear_req)
//   slave  : the arbiter (drives host_ready, busy, pipe_drop, mem_*)
interface mem_bank_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 18
);
  localparam int AW = $clog2(DEPTH);

  logic                  pipe_we;
  logic [AW-1:0]         pipe_addr;
  logic [DATA_WIDTH-1:0] pipe_data;

  logic                  host_valid;
  logic                  host_ready;
  logic [AW-1:0]         host_addr;
  logic [DATA_WIDTH-1:0] host_data;

  logic                  clear_req;
  logic                  busy;
  logic                  pipe_drop;

  logic                  mem_wea;
  logic [AW-1:0]         mem_addra;
  logic [DATA_WIDTH-1:0] mem_dia;

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output host_valid, host_addr, host_data,
    output clear_req,
    input  host_ready, busy, pipe_drop,
    input  mem_wea, mem_addra, mem_dia
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  host_valid, host_addr, host_data,
    input  clear_req,
    output host_ready, busy, pipe_drop,
    output mem_wea, mem_addra, mem_dia
  );
endinterface

// File: rtl/mem_bank_write_arbiter.sv
// rtl/mem_bank_write_arbiter.sv - shares one bank write port between pipeline, host and clear sweep
//
// Purpose: owns the bank's single write port. The pipeline writeback always
// wins a cycle. Host writes wait in a one-entry slot until a free cycle. A
// clear sweep writes CLEAR_VALUE to every address, both after reset and on
// clear_req. All mem_* outputs are registered: a write selected in cycle N
// drives the bank in cycle N+1.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave modport of mem_bank_write_arbiter_if
//           pipe_we/pipe_addr/pipe_data      pipeline writeback, never stalled
//           host_valid/host_ready/addr/data  host write handshake
//           clear_req                        one-cycle pulse, start a sweep
//           busy                             sweep in progress
//           pipe_drop                        sticky, a pipe write was discarded by a sweep
//           mem_wea/mem_addra/mem_dia        bank write port
module mem_bank_write_arbiter #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    DEPTH          = 18,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_bank_write_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  slot_full_q, slot_full_d;
  logic [AW-1:0]         slot_addr_q, slot_addr_d;
  logic [DATA_WIDTH-1:0] slot_data_q, slot_data_d;
  logic                  wea_q, wea_d;
  logic [AW-1:0]         addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dia_q, dia_d;
  logic                  drop_q, drop_d;

  logic host_ready;
  logic host_accept;

  // The slot cannot be refilled in the cycle it drains, so the host sees
  // ready one cycle after its previous write issues.
  assign host_ready  = !slot_full_q && (state_q == ST_RUN);
  assign host_accept = bus.host_valid && host_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_full_d = slot_full_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    wea_d       = 1'b0;
    addra_d     = addra_q;
    dia_d       = dia_q;
    drop_d      = drop_q;

    if (host_accept) begin
      slot_full_d = 1'b1;
      slot_addr_d = bus.host_addr;
      slot_data_d = bus.host_data;
    end

    case (state_q)
      ST_CLEAR: begin
        wea_d   = 1'b1;
        addra_d = cnt_q;
        dia_d   = CLEAR_VALUE;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
        // The sweep owns the port, so pipeline writes are lost and flagged.
        // A pending host write simply waits and issues after the sweep.
        if (bus.pipe_we) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
        end
        // The pipeline still gets the port in the clear_req cycle. The host
        // slot does not, so a pending host write outlives the sweep.
        if (bus.pipe_we) begin
          wea_d   = 1'b1;
          addra_d = bus.pipe_addr;
          dia_d   = bus.pipe_data;
        end else if (slot_full_q && !bus.clear_req) begin
          wea_d       = 1'b1;
          addra_d     = slot_addr_q;
          dia_d       = slot_data_q;
          slot_full_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q       <= '0;
      slot_full_q <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dia_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_full_q <= slot_full_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dia_q       <= dia_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.host_ready = host_ready;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.pipe_drop  = drop_q;
  assign bus.mem_wea    = wea_q;
  assign bus.mem_addra  = addra_q;
  assign bus.mem_dia    = dia_q;
endmodule

// File: tb/tb_mem_bank_write_arbiter.sv
// tb/tb_mem_bank_write_arbiter.sv - self-checking bench for mem_bank_write_arbiter
module tb_mem_bank_write_arbiter;
  localparam int DW    = 8;
  localparam int DEPTH = 18;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;
  logic bank_fill;
  int   total = 0;
  int   bad   = 0;

  mem_bank_write_arbiter_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  mem_bank_write_arbiter #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .CLEAR_VALUE(8'h00), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behaves like the bank that mem_* feeds.
  logic [DW-1:0] bank [DEPTH];
  always @(posedge clk) begin
    if (bank_fill) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= 8'hFF;
    end else if (bus.mem_wea && int'(bus.mem_addra) < DEPTH) begin
      bank[bus.mem_addra] <= bus.mem_dia;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    bus.pipe_we    = 1'b0;
    bus.pipe_addr  = '0;
    bus.pipe_data  = '0;
    bus.host_valid = 1'b0;
    bus.host_addr  = '0;
    bus.host_data  = '0;
    bus.clear_req  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++; if (bus.mem_wea !== 1'b0) begin bad++; $display("FAIL reset_wea actual=%0b required=0", bus.mem_wea); end
    total++; if (bus.mem_addra !== 5'd0) begin bad++; $display("FAIL reset_addra actual=%0d required=0", bus.mem_addra); end
    total++; if (bus.mem_dia !== 8'h00) begin bad++; $display("FAIL reset_dia actual=%0h required=0", bus.mem_dia); end
    total++; if (bus.pipe_drop !== 1'b0) begin bad++; $display("FAIL reset_pipe_drop actual=%0b required=0", bus.pipe_drop); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy actual=%0b required=1", bus.busy); end
    total++; if (bus.host_ready !== 1'b0) begin bad++; $display("FAIL reset_host_ready actual=%0b required=0", bus.host_ready); end
  endtask

  task automatic test_clear_sweep;
    bank_fill = 1'b1;
    @(negedge clk);
    bank_fill = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wea !== 1'b1 || bus.mem_addra !== AW'(i) || bus.mem_dia !== 8'h00) begin
        bad++; $display("FAIL boot_sweep i=%0d actual we=%0b addr=%0d data=%0h required we=1 addr=%0d data=0", i, bus.mem_wea, bus.mem_addra, bus.mem_dia, i);
      end
      total++;
      if (bus.busy !== (i < DEPTH - 1) || bus.host_ready !== (i == DEPTH - 1)) begin
        bad++; $display("FAIL boot_sweep_busy i=%0d actual busy=%0b ready=%0b required busy=%0b ready=%0b", i, bus.busy, bus.host_ready, (i < DEPTH - 1), (i == DEPTH - 1));
      end
    end
    @(negedge clk);
    total++; if (bus.mem_wea !== 1'b0) begin bad++; $display("FAIL boot_sweep_end_wea actual=%0b required=0", bus.mem_wea); end
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (bank[i] !== 8'h00) begin bad++; $display("FAIL boot_bank[%0d] actual=%0h required=0", i, bank[i]); end
    end
  endtask

  task automatic test_host_write;
    bus.host_valid = 1'b1;
    bus.host_addr  = 5'd5;
    bus.host_data  = 8'hA3;
    @(negedge clk);
    bus.host_valid = 1'b0;
    total++; if (bus.host_ready !== 1'b0) begin bad++; $display("FAIL host_ready_after_accept actual=%0b required=0", bus.host_ready); end
    total++; if (bus.mem_wea !== 1'b0) begin bad++; $display("FAIL host_early_wea actual=%0b required=0", bus.mem_wea); end
    @(negedge clk);
    total++;
    if (bus.mem_wea !== 1'b1 || bus.mem_addra !== 5'd5 || bus.mem_dia !== 8'hA3) begin
      bad++; $display("FAIL host_write actual we=%0b addr=%0d data=%0h required we=1 addr=5 data=a3", bus.mem_wea, bus.mem_addra, bus.mem_dia);
    end
    total++; if (bus.host_ready !== 1'b1) begin bad++; $display("FAIL host_ready_reopen actual=%0b required=1", bus.host_ready); end
  endtask

  task automatic test_pipe_over_host;
    bus.host_valid = 1'b1;
    bus.host_addr  = 5'd3;
    bus.host_data  = 8'h22;
    bus.pipe_we    = 1'b1;
    bus.pipe_addr  = 5'd3;
    bus.pipe_data  = 8'h11;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.host_valid = 1'b0;
      total++;
      if (bus.mem_wea !== 1'b1 || bus.mem_addra !== 5'd3 || bus.mem_dia !== 8'h11) begin
        bad++; $display("FAIL pipe_priority k=%0d actual we=%0b addr=%0d data=%0h required we=1 addr=3 data=11", k, bus.mem_wea, bus.mem_addra, bus.mem_dia);
      end
      total++; if (bus.host_ready !== 1'b0) begin bad++; $display("FAIL pipe_priority_ready k=%0d actual=%0b required=0", k, bus.host_ready); end
      if (k == 4) bus.pipe_we = 1'b0;
    end
    @(negedge clk);
    total++;
    if (bus.mem_wea !== 1'b1 || bus.mem_addra !== 5'd3 || bus.mem_dia !== 8'h22) begin
      bad++; $display("FAIL host_after_pipe actual we=%0b addr=%0d data=%0h required we=1 addr=3 data=22", bus.mem_wea, bus.mem_addra, bus.mem_dia);
    end
    @(negedge clk);
    total++; if (bank[3] !== 8'h22) begin bad++; $display("FAIL host_after_pipe_bank actual=%0h required=22", bank[3]); end
    total++; if (bus.mem_wea !== 1'b0) begin bad++; $display("FAIL host_after_pipe_idle actual=%0b required=0", bus.mem_wea); end
  endtask

  task automatic test_clear_with_pending;
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd2;
    bus.pipe_data = 8'h77;
    @(negedge clk);
    bus.pipe_we    = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_addr  = 5'd7;
    bus.host_data  = 8'h5C;
    bus.clear_req  = 1'b1;
    @(negedge clk);
    bus.host_valid = 1'b0;
    bus.clear_req  = 1'b0;
    total++;
    if (bus.mem_wea !== 1'b0 || bus.busy !== 1'b1 || bus.host_ready !== 1'b0) begin
      bad++; $display("FAIL clear_start actual we=%0b busy=%0b ready=%0b required we=0 busy=1 ready=0", bus.mem_wea, bus.busy, bus.host_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wea !== 1'b1 || bus.mem_addra !== AW'(i) || bus.mem_dia !== 8'h00) begin
        bad++; $display("FAIL req_sweep i=%0d actual we=%0b addr=%0d data=%0h required we=1 addr=%0d data=0", i, bus.mem_wea, bus.mem_addra, bus.mem_dia, i);
      end
    end
    @(negedge clk);
    total++;
    if (bus.mem_wea !== 1'b1 || bus.mem_addra !== 5'd7 || bus.mem_dia !== 8'h5C) begin
      bad++; $display("FAIL held_host_write actual we=%0b addr=%0d data=%0h required we=1 addr=7 data=5c", bus.mem_wea, bus.mem_addra, bus.mem_dia);
    end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bank[i] !== ((i == 7) ? 8'h5C : 8'h00)) begin
        bad++; $display("FAIL clear_bank[%0d] actual=%0h required=%0h", i, bank[i], ((i == 7) ? 8'h5C : 8'h00));
      end
    end
    total++; if (bus.pipe_drop !== 1'b0) begin bad++; $display("FAIL clear_no_drop actual=%0b required=0", bus.pipe_drop); end
  endtask

  task automatic test_pipe_drop;
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wea !== 1'b1 || bus.mem_addra !== AW'(i) || bus.mem_dia !== 8'h00) begin
        bad++; $display("FAIL drop_sweep i=%0d actual we=%0b addr=%0d data=%0h required we=1 addr=%0d data=0", i, bus.mem_wea, bus.mem_addra, bus.mem_dia, i);
      end
      if (i == 5) begin
        bus.pipe_we   = 1'b1;
        bus.pipe_addr = 5'd4;
        bus.pipe_data = 8'h99;
      end
      if (i == 6) bus.pipe_we = 1'b0;
    end
    @(negedge clk);
    total++; if (bus.mem_wea !== 1'b0) begin bad++; $display("FAIL drop_sweep_end actual=%0b required=0", bus.mem_wea); end
    total++; if (bus.pipe_drop !== 1'b1) begin bad++; $display("FAIL pipe_drop_set actual=%0b required=1", bus.pipe_drop); end
    total++; if (bank[4] !== 8'h00) begin bad++; $display("FAIL dropped_write_bank actual=%0h required=0", bank[4]); end
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd1;
    bus.pipe_data = 8'h42;
    @(negedge clk);
    bus.pipe_we = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.pipe_drop !== 1'b1) begin bad++; $display("FAIL pipe_drop_sticky actual=%0b required=1", bus.pipe_drop); end
    total++; if (bank[1] !== 8'h42) begin bad++; $display("FAIL run_pipe_bank actual=%0h required=42", bank[1]); end
  endtask

  task automatic test_reset_mid_sweep;
    bit stray;
    bus.host_valid = 1'b1;
    bus.host_addr  = 5'd9;
    bus.host_data  = 8'hEE;
    bus.clear_req  = 1'b1;
    @(negedge clk);
    bus.host_valid = 1'b0;
    bus.clear_req  = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wea !== 1'b1 || bus.mem_addra !== AW'(i)) begin
        bad++; $display("FAIL pre_reset_sweep i=%0d actual we=%0b addr=%0d required we=1 addr=%0d", i, bus.mem_wea, bus.mem_addra, i);
      end
    end
    reset = 1'b1;
    #1;
    total++; if (bus.mem_wea !== 1'b0) begin bad++; $display("FAIL midreset_wea actual=%0b required=0", bus.mem_wea); end
    total++; if (bus.mem_addra !== 5'd0 || bus.mem_dia !== 8'h00) begin bad++; $display("FAIL midreset_bus actual addr=%0d data=%0h required addr=0 data=0", bus.mem_addra, bus.mem_dia); end
    total++; if (bus.pipe_drop !== 1'b0) begin bad++; $display("FAIL midreset_pipe_drop actual=%0b required=0", bus.pipe_drop); end
    total++; if (bus.busy !== 1'b1 || bus.host_ready !== 1'b0) begin bad++; $display("FAIL midreset_busy actual busy=%0b ready=%0b required busy=1 ready=0", bus.busy, bus.host_ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_wea !== 1'b1 || bus.mem_addra !== AW'(i) || bus.mem_dia !== 8'h00) begin
        bad++; $display("FAIL restart_sweep i=%0d actual we=%0b addr=%0d data=%0h required we=1 addr=%0d data=0", i, bus.mem_wea, bus.mem_addra, bus.mem_dia, i);
      end
    end
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_wea !== 1'b0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL lost_host_write actual stray_write=%0b required=0", stray); end
    total++; if (bank[9] !== 8'h00) begin bad++; $display("FAIL lost_host_bank actual=%0h required=0", bank[9]); end
  endtask

  // Reference: the pipe write wins any cycle it is present. Otherwise the
  // oldest accepted host write issues. The host can be accepted only while
  // nothing is outstanding. With no write the port holds its last address/data.
  task automatic test_random;
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    logic [DW-1:0] model_bank [DEPTH];
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          pw, hv, acc;
    logic [AW-1:0] pa, ha;
    logic [DW-1:0] pd, hd;
    for (int i = 0; i < DEPTH; i++) model_bank[i] = 8'h00;
    exp_addr = AW'(DEPTH - 1);
    exp_data = 8'h00;
    for (int c = 0; c < 400; c++) begin
      pw = ($urandom_range(0, 2) == 0);
      hv = ($urandom_range(0, 1) == 1);
      pa = AW'($urandom_range(0, DEPTH - 1));
      ha = AW'($urandom_range(0, DEPTH - 1));
      pd = DW'($urandom);
      hd = DW'($urandom);
      bus.pipe_we    = pw;
      bus.pipe_addr  = pa;
      bus.pipe_data  = pd;
      bus.host_valid = hv;
      bus.host_addr  = ha;
      bus.host_data  = hd;
      acc = hv && (q_addr.size() == 0);
      if (pw) begin
        exp_we = 1'b1; exp_addr = pa; exp_data = pd;
      end else if (q_addr.size() != 0) begin
        exp_we = 1'b1; exp_addr = q_addr.pop_front(); exp_data = q_data.pop_front();
      end else begin
        exp_we = 1'b0;
      end
      if (acc) begin
        q_addr.push_back(ha);
        q_data.push_back(hd);
      end
      if (exp_we) model_bank[exp_addr] = exp_data;
      @(negedge clk);
      total++;
      if (bus.mem_wea !== exp_we || bus.mem_addra !== exp_addr || bus.mem_dia !== exp_data) begin
        bad++; $display("FAIL random_port c=%0d actual we=%0b addr=%0d data=%0h required we=%0b addr=%0d data=%0h", c, bus.mem_wea, bus.mem_addra, bus.mem_dia, exp_we, exp_addr, exp_data);
      end
      total++;
      if (bus.host_ready !== (q_addr.size() == 0)) begin
        bad++; $display("FAIL random_ready c=%0d actual=%0b required=%0b", c, bus.host_ready, (q_addr.size() == 0));
      end
    end
    idle_inputs();
    while (q_addr.size() != 0) begin
      exp_addr = q_addr.pop_front();
      exp_data = q_data.pop_front();
      model_bank[exp_addr] = exp_data;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bank[i] !== model_bank[i]) begin
        bad++; $display("FAIL random_bank[%0d] actual=%0h required=%0h", i, bank[i], model_bank[i]);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bank_fill = 1'b0;
    idle_inputs();
    test_reset();
    test_clear_sweep();
    test_host_write();
    test_pipe_over_host();
    test_clear_with_pending();
    test_pipe_drop();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
